pw_decoder: RTL and testbench
=============================

# pw_decoder

Pulse-width temporal decoder: the receiving end of the pulse-width gamma-cycle encoding driven into temporal operators such as the max unit. Monitors one temporal line per gamma cycle and converts the first pulse it sees into a binary width and onset phase, with a one-cycle valid strobe. Sits at the output boundary of a temporal datapath, feeding binary logic or a scoreboard.

## Interface
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle; phase range 0..GAMMA_CYCLE_WIDTH-1
- W, $clog2(GAMMA_CYCLE_WIDTH+1), width of value/onset outputs
- aclk  input  1  clock; all sampling on rising edge
- rst_n  input  1  asynchronous active-low reset
- grst  input  1  synchronous gamma-cycle start strobe, active-high; the edge sampling grst=1 is phase 0
- din  input  1  pulse-width temporal input, synchronous to aclk
- value  output  W  decoded pulse width in aclk cycles
- onset  output  W  phase of the first high sample of the decoded pulse
- valid  output  1  one-cycle strobe; value/onset/err meaningful while high
- err  output  1  with valid: pulse truncated by grst; without valid: extra pulse in same gamma cycle

## Operation
- Phase counter: 0 at grst edge, +1 per edge, saturates at GAMMA_CYCLE_WIDTH-1.
- States: IDLE (after reset, before first grst), ARMED (waiting for pulse), HIGH (counting), DONE (pulse reported, waiting for grst).
- IDLE: din ignored; grst -> ARMED.
- din ignored on any grst edge (phase 0 carries no data).
- ARMED: din=1 -> HIGH, count=1, onset=phase.
- HIGH: din=1 -> count+1, saturating at 2^W-1; din=0 -> valid, value=count, err=0, -> DONE.
- DONE: a low->high din transition -> err strobe alone (valid=0), pulse ignored, stay DONE.
- grst edge in ARMED: valid, value=0, onset=0, err=0 (null spike); stay ARMED with new phase 0.
- grst edge in HIGH with din=1: valid, value=count, err=1 (truncated); -> ARMED.
- grst edge in HIGH with din=0: normal completion; valid, value=count, err=0; -> ARMED.
- grst edge in DONE: no report; -> ARMED.
- value/onset hold last reported values between strobes; valid and err are single-cycle.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, phase 0, value 0, onset 0, valid 0, err 0.
- All outputs registered; updated on the edge that samples the deciding input, visible that cycle.
- Latency: valid rises on the edge sampling the first low din after a pulse, i.e. one edge after the last high sample.
- At most one valid per gamma cycle. An extra pulse produces no second valid.
- rst_n asserted mid-pulse: pulse discarded, no report; first pulse decoded only after the next grst.
- grst with no gap (back-to-back gamma cycles) supported every GAMMA_CYCLE_WIDTH edges or fewer.

## Configuration
- PW_DECODER_ONSET_EN defined: onset capture is compiled in, and onset reports the phase as described above.
- Not defined: the phase counter and onset register are removed; onset is tied to 0. value, valid and err behave identically.

## Test plan
- G=16, grst at edge 0, din high on phases 3..10, low at 11 -> valid at edge 11 only, value=8, onset=3, err=0.
- grst at edges 0 and 16, din never high -> edge 16: valid=1, value=0, onset=0, err=0; no other valid.
- din high from phase 12 through next grst edge (16) -> edge 16: valid=1, value=4, onset=12, err=1; next cycle decodes normally.
- din high on phases 2..4, then on 7..8 -> edge 5: valid, value=3, onset=2; edge 7: err=1, valid=0; no report at next grst.
- rst_n pulsed low during phase 6 of a pulse starting at phase 4 -> outputs 0 immediately; no valid until a grst opens a new cycle; din high before that grst ignored.
- Build without PW_DECODER_ONSET_EN, repeat the first scenario -> value=8, onset=0, valid at edge 11.

Source files
------------

// File: rtl/pw_decoder.sv
// Pulse-width temporal decoder: reports width and onset phase of the first pulse per gamma cycle.
// Onset capture is compiled in only when PW_DECODER_ONSET_EN is defined; otherwise onset is tied to 0.
module pw_decoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int W = $clog2(GAMMA_CYCLE_WIDTH + 1)
) (
  input  logic         aclk,
  input  logic         rst_n,
  input  logic         grst,
  input  logic         din,
  output logic [W-1:0] value,
  output logic [W-1:0] onset,
  output logic         valid,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] count;
  logic         din_q;
  logic         rpt, rpt_err, extra;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grst) state_nxt = ARMED;
      ARMED:   if (!grst && din) state_nxt = HIGH;
      HIGH:    if (grst) state_nxt = ARMED;
               else if (!din) state_nxt = DONE;
      DONE:    if (grst) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // din is never treated as data on a grst edge, so only HIGH reports on grst use it (truncation).
  always_comb begin
    rpt     = 1'b0;
    rpt_err = 1'b0;
    extra   = 1'b0;
    case (state)
      ARMED:   rpt = grst;
      HIGH: begin
        rpt     = grst || !din;
        rpt_err = grst && din;
      end
      DONE:    extra = !grst && din && !din_q;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      din_q <= 1'b0;
    end else begin
      din_q <= din;
      if (state == ARMED && !grst && din)
        count <= W'(1);
      else if (state == HIGH && !grst && din && count != '1)
        count <= count + W'(1);
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      err   <= 1'b0;
      value <= '0;
    end else begin
      valid <= rpt;
      err   <= rpt_err || extra;
      if (rpt) value <= (state == HIGH) ? count : '0;
    end
  end

`ifdef PW_DECODER_ONSET_EN
  logic [W-1:0] phase, phase_cur, onset_cap;

  // phase holds the phase of the previous edge; phase_cur is the phase of the edge being sampled
  assign phase_cur = grst ? '0 :
                     (phase == W'(GAMMA_CYCLE_WIDTH - 1)) ? phase : phase + W'(1);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      onset_cap <= '0;
      onset     <= '0;
    end else begin
      phase <= phase_cur;
      if (state == ARMED && !grst && din) onset_cap <= phase_cur;
      if (rpt) onset <= (state == HIGH) ? onset_cap : '0;
    end
  end
`else
  assign onset = '0;
`endif

endmodule

// File: tb/tb_pw_decoder.sv
// Bench for pw_decoder: scoreboard of expected strobes checked by a monitor, plus per-scenario checks.
module tb_pw_decoder;
  localparam int G = 16;
  localparam int W = $clog2(G + 1);

  logic         aclk  = 1'b0;
  logic         rst_n = 1'b0;
  logic         grst  = 1'b0;
  logic         din   = 1'b0;
  logic [W-1:0] value, onset;
  logic         valid, err;

  typedef struct {
    int           edge_n;
    logic         v;
    logic [W-1:0] val;
    logic [W-1:0] ons;
    logic         e;
  } ev_t;

  ev_t          sb[$];
  ev_t          x;
  int           ecount   = 0;
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] hold_val = '0;
  logic [W-1:0] hold_ons = '0;

  pw_decoder #(.GAMMA_CYCLE_WIDTH(G)) dut (
    .aclk  (aclk),
    .rst_n (rst_n),
    .grst  (grst),
    .din   (din),
    .value (value),
    .onset (onset),
    .valid (valid),
    .err   (err)
  );

  always #5 aclk = ~aclk;

  function automatic int eo(input int p);
`ifdef PW_DECODER_ONSET_EN
    return p;
`else
    return 0;
`endif
  endfunction

  // Monitor: every strobe must match the scoreboard head; quiet cycles must hold the last report.
  always @(posedge aclk) begin
    ecount = ecount + 1;
    #1;
    if (rst_n) begin
      checks++;
      if (valid || err) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe edge=%0d valid=%0b err=%0b value=%0d required no strobe",
                   ecount, valid, err, value);
        end else begin
          x = sb.pop_front();
          if (!x.v) begin
            x.val = hold_val;
            x.ons = hold_ons;
          end
          if (ecount !== x.edge_n || valid !== x.v || err !== x.e || value !== x.val || onset !== x.ons) begin
            failures++;
            $display("FAIL strobe edge=%0d valid=%0b err=%0b value=%0d onset=%0d required edge=%0d valid=%0b err=%0b value=%0d onset=%0d",
                     ecount, valid, err, value, onset, x.edge_n, x.v, x.e, x.val, x.ons);
          end
          hold_val = x.val;
          hold_ons = x.ons;
        end
      end else if (value !== hold_val || onset !== hold_ons) begin
        failures++;
        $display("FAIL hold edge=%0d value=%0d onset=%0d required value=%0d onset=%0d",
                 ecount, value, onset, hold_val, hold_ons);
      end
    end
  end

  task automatic drive(input bit g, input bit d);
    @(negedge aclk);
    grst = g;
    din  = d;
  endtask

  // Expected strobe on the edge about to sample the inputs just driven.
  task automatic expect_ev(input bit v, input int val, input int ons, input bit e);
    sb.push_back('{edge_n: ecount + 1, v: v, val: W'(val), ons: W'(ons), e: e});
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({valid, err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_strobes valid=%0b err=%0b required 0 0", valid, err);
    end
    checks++;
    if (value !== '0 || onset !== '0) begin
      failures++;
      $display("FAIL reset_data value=%0d onset=%0d required 0 0", value, onset);
    end
    @(negedge aclk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pulse;
    for (int ph = 0; ph < G; ph++) begin
      drive(ph == 0, ph >= 3 && ph <= 10);
      if (ph == 11) expect_ev(1, 8, eo(3), 0);
    end
  endtask

  task automatic test_null_spike;
    for (int ph = 0; ph <= G; ph++) begin
      drive(ph == 0 || ph == G, 1'b0);
      if (ph == G) expect_ev(1, 0, 0, 0);
    end
  endtask

  task automatic test_truncate;
    for (int ph = 1; ph <= G; ph++) begin
      drive(ph == G, ph >= 12);
      if (ph == G) expect_ev(1, 4, eo(12), 1);
    end
    for (int ph = 1; ph <= 7; ph++) begin
      drive(1'b0, ph == 5 || ph == 6);
      if (ph == 7) expect_ev(1, 2, eo(5), 0);
    end
  endtask

  task automatic test_extra_pulse;
    for (int ph = 8; ph < G; ph++) drive(1'b0, 1'b0);
    for (int ph = 0; ph < G; ph++) begin
      drive(ph == 0, (ph >= 2 && ph <= 4) || (ph >= 7 && ph <= 8));
      if (ph == 5) expect_ev(1, 3, eo(2), 0);
      if (ph == 7) expect_ev(0, 0, 0, 1);
    end
    drive(1'b1, 1'b0);
    for (int ph = 1; ph <= 3; ph++) drive(1'b0, 1'b0);
  endtask

  task automatic test_saturate;
    drive(1'b1, 1'b0);
    expect_ev(1, 0, 0, 0);
    for (int ph = 1; ph <= 60; ph++) begin
      drive(1'b0, ph >= 20 && ph <= 59);
      if (ph == 60) expect_ev(1, 31, eo(15), 0);
    end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b0);
    for (int ph = 1; ph <= 6; ph++) drive(1'b0, ph >= 4);
    @(posedge aclk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, err} !== 2'b00 || value !== '0 || onset !== '0) begin
      failures++;
      $display("FAIL reset_mid valid=%0b err=%0b value=%0d onset=%0d required all 0",
               valid, err, value, onset);
    end
    hold_val = '0;
    hold_ons = '0;
    @(negedge aclk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    for (int ph = 0; ph <= 5; ph++) begin
      drive(ph == 0, ph == 2 || ph == 3);
      if (ph == 4) expect_ev(1, 2, eo(2), 0);
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
    @(posedge aclk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes pending=%0d required 0 (next edge=%0d)", sb.size(), sb[0].edge_n);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_null_spike();
    test_truncate();
    test_extra_pulse();
    test_saturate();
    test_reset_mid();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
